// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Bundle between the instruction decoder / program counter side
//             (master) and the fetch sequencer (slave).
//  Signals  : start/start_addr, pc, step, br_taken/br_target,
//             loop_set/loop_end/loop_cnt, halt       -> into the sequencer
//             pc_inc/pc_load/pc_preset, running, loop_active,
//             loop_remain, done                      -> out of the sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] pc;
    logic              step;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              loop_set;
    logic [ADDR_W-1:0] loop_end;
    logic [CNT_W-1:0]  loop_cnt;
    logic              halt;
    logic              pc_inc;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_preset;
    logic              running;
    logic              loop_active;
    logic [CNT_W-1:0]  loop_remain;
    logic              done;

    modport master (
        output start, start_addr, pc, step, br_taken, br_target,
               loop_set, loop_end, loop_cnt, halt,
        input  pc_inc, pc_load, pc_preset, running, loop_active,
               loop_remain, done
    );

    modport slave (
        input  start, start_addr, pc, step, br_taken, br_target,
               loop_set, loop_end, loop_cnt, halt,
        output pc_inc, pc_load, pc_preset, running, loop_active,
               loop_remain, done
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Fetch/sequence control for a presettable program counter.
//             Handles start, stepping, branches, halt and one zero-overhead
//             hardware loop. PC controls are Mealy outputs registered by the
//             counter on the same clk edge.
//  Ports    : clk, rst (sync, active high, shared with the counter)
//             bus (pc_sequencer_if.slave) - decoder inputs, counter controls
//             and status outputs
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pc_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_loop_start, w_loop_start_nxt;
    logic [ADDR_W-1:0] r_loop_end, w_loop_end_nxt;
    logic [CNT_W-1:0]  r_loop_remain, w_loop_remain_nxt;
    logic              r_loop_active, w_loop_active_nxt;
    logic              r_done, w_done_nxt;

    logic              w_inc;
    logic              w_load;
    logic [ADDR_W-1:0] w_preset;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_loop_start  <= '0;
            r_loop_end    <= '0;
            r_loop_remain <= '0;
            r_loop_active <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_loop_start  <= w_loop_start_nxt;
            r_loop_end    <= w_loop_end_nxt;
            r_loop_remain <= w_loop_remain_nxt;
            r_loop_active <= w_loop_active_nxt;
            r_done        <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_loop_start_nxt  = r_loop_start;
        w_loop_end_nxt    = r_loop_end;
        w_loop_remain_nxt = r_loop_remain;
        w_loop_active_nxt = r_loop_active;
        w_done_nxt        = 1'b0;
        w_inc             = 1'b0;
        w_load            = 1'b0;
        w_preset          = '0;

        // The counter shares rst, so nothing may be driven toward it while
        // reset is held; the register block ignores the next-state values.
        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (bus.step) begin
                        if (bus.halt) begin
                            w_state_nxt       = S_HALTED;
                            w_done_nxt        = 1'b1;
                            w_loop_active_nxt = 1'b0;
                            w_loop_remain_nxt = '0;
                        end else if (bus.br_taken) begin
                            // Branches leave the loop armed on purpose.
                            w_load   = 1'b1;
                            w_preset = bus.br_target;
                        end else if (bus.loop_set) begin
                            w_inc = 1'b1;
                            if (bus.loop_cnt > CNT_W'(1)) begin
                                w_loop_start_nxt  = bus.pc + ADDR_W'(1);
                                w_loop_end_nxt    = bus.loop_end;
                                w_loop_remain_nxt = bus.loop_cnt;
                                w_loop_active_nxt = 1'b1;
                            end else begin
                                // 0 or 1 passes: body simply runs through once.
                                w_loop_active_nxt = 1'b0;
                                w_loop_remain_nxt = '0;
                            end
                        end else if (r_loop_active && (bus.pc == r_loop_end)) begin
                            if (r_loop_remain > CNT_W'(1)) begin
                                w_load            = 1'b1;
                                w_preset          = r_loop_start;
                                w_loop_remain_nxt = r_loop_remain - CNT_W'(1);
                            end else begin
                                w_inc             = 1'b1;
                                w_loop_active_nxt = 1'b0;
                                w_loop_remain_nxt = '0;
                            end
                        end else begin
                            w_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and HALTED: only start is honoured.
                    if (bus.start) begin
                        w_load            = 1'b1;
                        w_preset          = bus.start_addr;
                        w_loop_active_nxt = 1'b0;
                        w_loop_remain_nxt = '0;
                        w_state_nxt       = S_RUN;
                    end
                end
            endcase
        end
    end

    assign bus.pc_inc      = w_inc;
    assign bus.pc_load     = w_load;
    assign bus.pc_preset   = w_preset;
    assign bus.running     = (r_state == S_RUN);
    assign bus.loop_active = r_loop_active;
    assign bus.loop_remain = r_loop_remain;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer. Includes a model of the
//             presettable program counter (increment has priority over load).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(8), .CNT_W(8)) bus ();

    pc_sequencer #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Program counter model driven by the sequencer controls.
    logic [7:0] cnt;
    assign bus.pc = cnt;
    always @(posedge clk) begin
        if (rst)              cnt <= 8'h00;
        else if (bus.pc_inc)  cnt <= cnt + 8'h01;
        else if (bus.pc_load) cnt <= bus.pc_preset;
    end

    int checks   = 0;
    int failures = 0;
    int excl_viol = 0;

    always @(negedge clk) begin
        if (bus.pc_inc && bus.pc_load) excl_viol++;
    end

    typedef struct {
        logic       rst, start;
        logic [7:0] sa;
        logic       step, br;
        logic [7:0] bt;
        logic       ls;
        logic [7:0] le, lc;
        logic       halt;
        logic       e_inc, e_load;
        logic [7:0] e_pre, e_pc;
        logic       e_run, e_la;
        logic [7:0] e_rem;
        logic       e_done;
    } vec_t;

    function automatic vec_t v(
        input logic r, input logic s, input logic [7:0] sa,
        input logic st, input logic br, input logic [7:0] bt,
        input logic ls, input logic [7:0] le, input logic [7:0] lc,
        input logic h,
        input logic ei, input logic el, input logic [7:0] ep,
        input logic [7:0] epc, input logic er, input logic ela,
        input logic [7:0] erm, input logic ed);
        vec_t x;
        x.rst = r; x.start = s; x.sa = sa; x.step = st; x.br = br; x.bt = bt;
        x.ls = ls; x.le = le; x.lc = lc; x.halt = h;
        x.e_inc = ei; x.e_load = el; x.e_pre = ep; x.e_pc = epc;
        x.e_run = er; x.e_la = ela; x.e_rem = erm; x.e_done = ed;
        return x;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    // Apply one vector just after a rising edge, check the Mealy outputs
    // mid-cycle, then check registered state and the new pc after the edge.
    task automatic apply(input vec_t x, input int idx);
        rst            = x.rst;
        bus.start      = x.start;
        bus.start_addr = x.sa;
        bus.step       = x.step;
        bus.br_taken   = x.br;
        bus.br_target  = x.bt;
        bus.loop_set   = x.ls;
        bus.loop_end   = x.le;
        bus.loop_cnt   = x.lc;
        bus.halt       = x.halt;
        #1;
        chk("pc_inc",    idx, {7'd0, bus.pc_inc},  {7'd0, x.e_inc});
        chk("pc_load",   idx, {7'd0, bus.pc_load}, {7'd0, x.e_load});
        chk("pc_preset", idx, bus.pc_preset, x.e_pre);
        @(posedge clk);
        #1;
        chk("pc",          idx, cnt, x.e_pc);
        chk("running",     idx, {7'd0, bus.running},     {7'd0, x.e_run});
        chk("loop_active", idx, {7'd0, bus.loop_active}, {7'd0, x.e_la});
        chk("loop_remain", idx, bus.loop_remain, x.e_rem);
        chk("done",        idx, {7'd0, bus.done},        {7'd0, x.e_done});
    endtask

    // Shorthands: a plain step, and an idle cycle.
    function automatic vec_t stp(input logic ei, input logic el, input logic [7:0] ep,
                                 input logic [7:0] epc, input logic ela,
                                 input logic [7:0] erm);
        return v(0,0,8'h00, 1,0,8'h00, 0,8'h00,8'h00, 0, ei,el,ep, epc,1,ela,erm,0);
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.start_addr = 0; bus.step = 0; bus.br_taken = 0;
        bus.br_target = 0; bus.loop_set = 0; bus.loop_end = 0; bus.loop_cnt = 0;
        bus.halt = 0;
        @(posedge clk); #1;

        //            r s sa     st br bt     ls le     lc     h  inc ld pre    pc     run la rem   done
        // Reset state, and reset masks start/step.
        tbl.push_back(v(1,0,8'h00, 0,0,8'h00, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h00,0,0,8'h00,0));
        tbl.push_back(v(1,1,8'h33, 1,1,8'h44, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h00,0,0,8'h00,0));
        // Start at 0x10 and three steps.
        tbl.push_back(v(0,1,8'h10, 0,0,8'h00, 0,8'h00,8'h00, 0, 0,1,8'h10, 8'h10,1,0,8'h00,0));
        tbl.push_back(stp(1,0,8'h00, 8'h11,0,8'h00));
        tbl.push_back(stp(1,0,8'h00, 8'h12,0,8'h00));
        tbl.push_back(stp(1,0,8'h00, 8'h13,0,8'h00));
        // No step, and start ignored in RUN.
        tbl.push_back(v(0,0,8'h00, 0,0,8'h00, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h13,1,0,8'h00,0));
        tbl.push_back(v(0,1,8'h77, 0,0,8'h00, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h13,1,0,8'h00,0));
        // Branch to 0x20, then 3-pass loop over 0x21..0x22.
        tbl.push_back(v(0,0,8'h00, 1,1,8'h20, 0,8'h00,8'h00, 0, 0,1,8'h20, 8'h20,1,0,8'h00,0));
        tbl.push_back(v(0,0,8'h00, 1,0,8'h00, 1,8'h22,8'h03, 0, 1,0,8'h00, 8'h21,1,1,8'h03,0));
        tbl.push_back(stp(1,0,8'h00, 8'h22,1,8'h03));
        tbl.push_back(stp(0,1,8'h21, 8'h21,1,8'h02));
        tbl.push_back(stp(1,0,8'h00, 8'h22,1,8'h02));
        tbl.push_back(stp(0,1,8'h21, 8'h21,1,8'h01));
        tbl.push_back(stp(1,0,8'h00, 8'h22,1,8'h01));
        tbl.push_back(stp(1,0,8'h00, 8'h23,0,8'h00));
        // Branch to 0x05, halt wins over branch.
        tbl.push_back(v(0,0,8'h00, 1,1,8'h05, 0,8'h00,8'h00, 0, 0,1,8'h05, 8'h05,1,0,8'h00,0));
        tbl.push_back(v(0,0,8'h00, 1,1,8'h40, 0,8'h00,8'h00, 1, 0,0,8'h00, 8'h05,0,0,8'h00,1));
        tbl.push_back(v(0,0,8'h00, 0,0,8'h00, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h05,0,0,8'h00,0));
        tbl.push_back(v(0,0,8'h00, 1,0,8'h00, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h05,0,0,8'h00,0));
        tbl.push_back(v(0,0,8'h00, 1,1,8'h50, 1,8'h09,8'h05, 1, 0,0,8'h00, 8'h05,0,0,8'h00,0));
        tbl.push_back(v(0,1,8'h30, 0,0,8'h00, 0,8'h00,8'h00, 0, 0,1,8'h30, 8'h30,1,0,8'h00,0));
        // Loop 0x31..0x32 x2; branching out and back in keeps it armed.
        tbl.push_back(v(0,0,8'h00, 1,0,8'h00, 1,8'h32,8'h02, 0, 1,0,8'h00, 8'h31,1,1,8'h02,0));
        tbl.push_back(v(0,0,8'h00, 1,1,8'h50, 0,8'h00,8'h00, 0, 0,1,8'h50, 8'h50,1,1,8'h02,0));
        tbl.push_back(v(0,0,8'h00, 1,1,8'h32, 0,8'h00,8'h00, 0, 0,1,8'h32, 8'h32,1,1,8'h02,0));
        tbl.push_back(stp(0,1,8'h31, 8'h31,1,8'h01));
        tbl.push_back(stp(1,0,8'h00, 8'h32,1,8'h01));
        tbl.push_back(stp(1,0,8'h00, 8'h33,0,8'h00));
        // Re-arm while active overwrites the previous loop.
        tbl.push_back(v(0,0,8'h00, 1,0,8'h00, 1,8'h35,8'h04, 0, 1,0,8'h00, 8'h34,1,1,8'h04,0));
        tbl.push_back(v(0,0,8'h00, 1,0,8'h00, 1,8'h36,8'h02, 0, 1,0,8'h00, 8'h35,1,1,8'h02,0));
        tbl.push_back(stp(1,0,8'h00, 8'h36,1,8'h02));
        tbl.push_back(stp(0,1,8'h35, 8'h35,1,8'h01));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Wrap-around loop: start 0xFE, body 0xFF..0x00, two passes.
        apply(v(1,0,8'h00, 0,0,8'h00, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h00,0,0,8'h00,0), 100);
        apply(v(0,1,8'hFE, 0,0,8'h00, 0,8'h00,8'h00, 0, 0,1,8'hFE, 8'hFE,1,0,8'h00,0), 101);
        apply(v(0,0,8'h00, 1,0,8'h00, 1,8'h00,8'h02, 0, 1,0,8'h00, 8'hFF,1,1,8'h02,0), 102);
        apply(stp(1,0,8'h00, 8'h00,1,8'h02), 103);
        apply(stp(0,1,8'hFF, 8'hFF,1,8'h01), 104);
        apply(stp(1,0,8'h00, 8'h00,1,8'h01), 105);
        apply(stp(1,0,8'h00, 8'h01,0,8'h00), 106);

        // Reset mid-loop with loop_remain=2, step held high throughout.
        apply(v(0,0,8'h00, 1,1,8'h40, 0,8'h00,8'h00, 0, 0,1,8'h40, 8'h40,1,0,8'h00,0), 110);
        apply(v(0,0,8'h00, 1,0,8'h00, 1,8'h41,8'h03, 0, 1,0,8'h00, 8'h41,1,1,8'h03,0), 111);
        apply(stp(0,1,8'h41, 8'h41,1,8'h02), 112);
        apply(v(1,0,8'h00, 1,0,8'h00, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h00,0,0,8'h00,0), 113);
        apply(v(0,0,8'h00, 1,0,8'h00, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h00,0,0,8'h00,0), 114);
        apply(v(0,0,8'h00, 1,0,8'h00, 0,8'h00,8'h00, 0, 0,0,8'h00, 8'h00,0,0,8'h00,0), 115);
        apply(v(0,1,8'h60, 0,0,8'h00, 0,8'h00,8'h00, 0, 0,1,8'h60, 8'h60,1,0,8'h00,0), 116);

        // loop_cnt=1 then loop_cnt=0: never armed, body falls through once.
        apply(v(0,0,8'h00, 1,0,8'h00, 1,8'h62,8'h01, 0, 1,0,8'h00, 8'h61,1,0,8'h00,0), 120);
        apply(stp(1,0,8'h00, 8'h62,0,8'h00), 121);
        apply(stp(1,0,8'h00, 8'h63,0,8'h00), 122);
        apply(v(0,0,8'h00, 1,0,8'h00, 1,8'h65,8'h00, 0, 1,0,8'h00, 8'h64,1,0,8'h00,0), 123);
        apply(stp(1,0,8'h00, 8'h65,0,8'h00), 124);
        apply(stp(1,0,8'h00, 8'h66,0,8'h00), 125);

        checks++;
        if (excl_viol != 0) begin
            failures++;
            $display("FAIL inc_load_exclusive actual=%0d cycles required=0", excl_viol);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
